// File: rtl/meteo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : meteo_pkg
//  Description : Shared state encoding and default parameter constants for
//                the meteo sensor BCD conversion scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package meteo_pkg;

    localparam int DEF_INPUT_WIDTH    = 10;
    localparam int DEF_DECIMAL_DIGITS = 3;
    localparam int DEF_NUM_CH         = 3;
    localparam int DEF_TIMEOUT        = 255;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } sched_state_t;

endpackage : meteo_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter. The search begins at the
//                channel after the last grant and wraps around.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_CH = 3,
    parameter int IDX_W  = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  last_grant,
    output logic [NUM_CH-1:0] grant,
    output logic [IDX_W-1:0]  grant_idx,
    output logic              valid
);

    // First requester found walking forward from last_grant+1 wins
    always_comb begin
        int cand;
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        cand      = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = int'(last_grant) + 1 + i;
            if (cand >= NUM_CH) cand = cand - NUM_CH;
            if (cand >= NUM_CH) cand = cand - NUM_CH;
            if (!valid && req[cand]) begin
                valid       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/bcd_convert_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_convert_scheduler
//  Description : Shares one external binary-to-BCD converter between several
//                sensor channels. Grants round-robin, converts signed values
//                to magnitude + sign, waits for the converter with a timeout
//                and stores per-channel BCD results with sign/error flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_convert_scheduler
    import meteo_pkg::*;
#(
    parameter int INPUT_WIDTH    = DEF_INPUT_WIDTH,
    parameter int DECIMAL_DIGITS = DEF_DECIMAL_DIGITS,
    parameter int NUM_CH         = DEF_NUM_CH,
    parameter int TIMEOUT        = DEF_TIMEOUT
) (
    input  logic                               i_Clock,
    input  logic                               i_Reset,
    input  logic [NUM_CH-1:0]                  i_Req,
    input  logic [NUM_CH*INPUT_WIDTH-1:0]      i_Value,
    input  logic [NUM_CH-1:0]                  i_Signed,
    output logic [INPUT_WIDTH-1:0]             o_Conv_Binary,
    output logic                               o_Conv_Start,
    input  logic [DECIMAL_DIGITS*4-1:0]        i_Conv_BCD,
    input  logic                               i_Conv_DV,
    output logic [NUM_CH*DECIMAL_DIGITS*4-1:0] o_BCD,
    output logic [NUM_CH-1:0]                  o_Neg,
    output logic [NUM_CH-1:0]                  o_Err,
    output logic [NUM_CH-1:0]                  o_Ack,
    output logic                               o_Busy
);

    localparam int BCD_W = DECIMAL_DIGITS * 4;
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    sched_state_t           state;
    logic [IDX_W-1:0]       last_grant;
    logic [IDX_W-1:0]       cur_ch;
    logic                   cur_neg;
    logic [CNT_W-1:0]       wait_cnt;

    logic [NUM_CH-1:0]      qual_req;
    logic [NUM_CH-1:0]      grant_onehot;
    logic [IDX_W-1:0]       grant_idx;
    logic                   grant_valid;

    logic [INPUT_WIDTH-1:0] sel_value;
    logic                   sel_signed;
    logic                   sel_neg;
    logic [INPUT_WIDTH-1:0] sel_mag;

    // A channel whose ack is showing this cycle must not be granted again
    assign qual_req = i_Req & ~o_Ack;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_arb (
        .req        (qual_req),
        .last_grant (last_grant),
        .grant      (grant_onehot),
        .grant_idx  (grant_idx),
        .valid      (grant_valid)
    );

    // Mux the granted channel's value/sign flag and reduce to magnitude + sign
    always_comb begin
        sel_value  = '0;
        sel_signed = 1'b0;
        for (int n = 0; n < NUM_CH; n++) begin
            sel_value  = sel_value | (i_Value[n*INPUT_WIDTH +: INPUT_WIDTH]
                                      & {INPUT_WIDTH{grant_onehot[n]}});
            sel_signed = sel_signed | (i_Signed[n] & grant_onehot[n]);
        end
        sel_neg = sel_signed & sel_value[INPUT_WIDTH-1];
        // Negation wraps in INPUT_WIDTH bits, so the most negative value maps
        // to its unsigned magnitude (e.g. -512 -> 512 for 10 bits)
        sel_mag = sel_neg ? (~sel_value + INPUT_WIDTH'(1)) : sel_value;
    end

    // Scheduler FSM with all outputs registered
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state         <= ST_IDLE;
            last_grant    <= IDX_W'(NUM_CH - 1);
            cur_ch        <= '0;
            cur_neg       <= 1'b0;
            wait_cnt      <= '0;
            o_Conv_Binary <= '0;
            o_Conv_Start  <= 1'b0;
            o_BCD         <= '0;
            o_Neg         <= '0;
            o_Err         <= '0;
            o_Ack         <= '0;
            o_Busy        <= 1'b0;
        end else begin
            o_Ack        <= '0;
            o_Conv_Start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        cur_ch        <= grant_idx;
                        cur_neg       <= sel_neg;
                        o_Conv_Binary <= sel_mag;
                        last_grant    <= grant_idx;
                        o_Conv_Start  <= 1'b1;
                        o_Busy        <= 1'b1;
                        state         <= ST_START;
                    end
                end
                ST_START: begin
                    wait_cnt <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_Conv_DV) begin
                        // A result arriving on the last allowed cycle still counts
                        o_BCD[int'(cur_ch)*BCD_W +: BCD_W] <= i_Conv_BCD;
                        o_Neg[cur_ch] <= cur_neg;
                        o_Err[cur_ch] <= 1'b0;
                        o_Ack[cur_ch] <= 1'b1;
                        o_Busy        <= 1'b0;
                        state         <= ST_IDLE;
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        o_Err[cur_ch] <= 1'b1;
                        o_Ack[cur_ch] <= 1'b1;
                        o_Busy        <= 1'b0;
                        state         <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    o_Busy <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : bcd_convert_scheduler
`default_nettype wire

// File: tb/tb_bcd_convert_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_convert_scheduler
//  Description : Directed self-checking bench for bcd_convert_scheduler. The
//                bench plays the part of the external converter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_convert_scheduler;

    localparam int W  = 10;
    localparam int D  = 3;
    localparam int N  = 3;
    localparam int BW = D * 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*W-1:0]  value;
    logic [N-1:0]    sgn;
    logic [W-1:0]    conv_bin;
    logic            conv_start;
    logic [BW-1:0]   conv_bcd;
    logic            conv_dv;
    logic [N*BW-1:0] bcd;
    logic [N-1:0]    neg;
    logic [N-1:0]    err;
    logic [N-1:0]    ack;
    logic            busy;

    int total = 0;
    int bad   = 0;
    int multi_ack = 0;

    always #5 clk = ~clk;

    bcd_convert_scheduler #(
        .INPUT_WIDTH    (W),
        .DECIMAL_DIGITS (D),
        .NUM_CH         (N),
        .TIMEOUT        (255)
    ) dut (
        .i_Clock       (clk),
        .i_Reset       (rst),
        .i_Req         (req),
        .i_Value       (value),
        .i_Signed      (sgn),
        .o_Conv_Binary (conv_bin),
        .o_Conv_Start  (conv_start),
        .i_Conv_BCD    (conv_bcd),
        .i_Conv_DV     (conv_dv),
        .o_BCD         (bcd),
        .o_Neg         (neg),
        .o_Err         (err),
        .o_Ack         (ack),
        .o_Busy        (busy)
    );

    always @(negedge clk) if ($countones(ack) > 1) multi_ack++;

    // Wait (bounded) for the converter start pulse, sampled on negedges
    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (conv_start === 1'b1) ok = 1'b1;
        end
    endtask

    // One-cycle result-valid pulse from the modelled converter
    task automatic pulse_dv(input logic [BW-1:0] b);
        conv_bcd = b;
        conv_dv  = 1'b1;
        @(negedge clk);
        conv_dv  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        total++; if (bcd !== '0)        begin bad++; $display("FAIL reset_bcd: got %h want 0", bcd); end
        total++; if ({neg, err, ack} !== '0) begin bad++; $display("FAIL reset_flags: got %b want 0", {neg, err, ack}); end
        total++; if ({busy, conv_start} !== 2'b00) begin bad++; $display("FAIL reset_busy_start: got %b want 00", {busy, conv_start}); end
        total++; if (conv_bin !== '0)   begin bad++; $display("FAIL reset_conv_bin: got %0d want 0", conv_bin); end
    endtask

    task automatic test_unsigned();
        value = '0; value[0 +: W] = 10'd273; sgn = '0; req = 3'b001;
        @(negedge clk);
        total++; if (conv_start !== 1'b1) begin bad++; $display("FAIL uns_start: got %b want 1", conv_start); end
        total++; if (conv_bin !== 10'd273) begin bad++; $display("FAIL uns_bin: got %0d want 273", conv_bin); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL uns_busy: got %b want 1", busy); end
        @(negedge clk);
        total++; if (conv_start !== 1'b0) begin bad++; $display("FAIL uns_start_len: got %b want 0", conv_start); end
        repeat (38) @(negedge clk);
        pulse_dv(12'h273);
        total++; if (ack !== 3'b001) begin bad++; $display("FAIL uns_ack: got %b want 001", ack); end
        total++; if (bcd[0 +: BW] !== 12'h273) begin bad++; $display("FAIL uns_bcd: got %h want 273", bcd[0 +: BW]); end
        total++; if ({neg[0], err[0]} !== 2'b00) begin bad++; $display("FAIL uns_neg_err: got %b want 00", {neg[0], err[0]}); end
        req = '0;
        @(negedge clk);
        total++; if ({ack, busy} !== 4'b0000) begin bad++; $display("FAIL uns_idle: got %b want 0000", {ack, busy}); end
    endtask

    task automatic test_signed();
        bit ok;
        value[W +: W] = 10'h3E7; sgn = 3'b010; req = 3'b010;
        wait_start(ok);
        total++; if (!ok) begin bad++; $display("FAIL sgn_start: got 0 want 1"); end
        total++; if (conv_bin !== 10'd25) begin bad++; $display("FAIL sgn_bin25: got %0d want 25", conv_bin); end
        value[W +: W] = 10'h000;
        repeat (5) @(negedge clk);
        total++; if (conv_bin !== 10'd25) begin bad++; $display("FAIL sgn_hold: got %0d want 25", conv_bin); end
        pulse_dv(12'h025);
        total++; if (ack !== 3'b010) begin bad++; $display("FAIL sgn_ack: got %b want 010", ack); end
        total++; if ({bcd[BW +: BW], neg[1]} !== {12'h025, 1'b1}) begin bad++; $display("FAIL sgn_res25: got %h/%b want 025/1", bcd[BW +: BW], neg[1]); end
        req = '0;
        @(negedge clk);
        value[W +: W] = 10'h200; req = 3'b010;
        wait_start(ok);
        total++; if (conv_bin !== 10'd512) begin bad++; $display("FAIL sgn_bin512: got %0d want 512", conv_bin); end
        repeat (3) @(negedge clk);
        pulse_dv(12'h512);
        total++; if ({bcd[BW +: BW], neg[1]} !== {12'h512, 1'b1}) begin bad++; $display("FAIL sgn_res512: got %h/%b want 512/1", bcd[BW +: BW], neg[1]); end
        req = '0; sgn = '0;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        int exp_ch[6] = '{0, 1, 2, 0, 1, 2};
        logic [N-1:0] exp_ack;
        bit ok;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        value = '0; value[0 +: W] = 10'd1; value[W +: W] = 10'd2; value[2*W +: W] = 10'd3;
        sgn = '0; req = 3'b111;
        for (int k = 0; k < 6; k++) begin
            wait_start(ok);
            total++; if (!ok) begin bad++; $display("FAIL rr_start%0d: got 0 want 1", k); end
            total++; if (conv_bin !== W'(exp_ch[k] + 1)) begin bad++; $display("FAIL rr_grant%0d: got ch%0d want ch%0d", k, int'(conv_bin) - 1, exp_ch[k]); end
            repeat (2) @(negedge clk);
            pulse_dv(BW'(exp_ch[k] + 1));
            exp_ack = N'(1) << exp_ch[k];
            total++; if (ack !== exp_ack) begin bad++; $display("FAIL rr_ack%0d: got %b want %b", k, ack, exp_ack); end
            req = req & ~ack;
            if (k == 2) req = 3'b111;
        end
        req = '0;
        @(negedge clk);
        total++; if (bcd !== {12'h003, 12'h002, 12'h001}) begin bad++; $display("FAIL rr_bcd: got %h want 003002001", bcd); end
    endtask

    task automatic test_timeout();
        bit ok;
        int n;
        req = 3'b100;
        wait_start(ok);
        n = 0;
        for (int i = 0; i < 400 && ack === '0; i++) begin
            @(negedge clk);
            n++;
        end
        total++; if (n !== 256) begin bad++; $display("FAIL to_cycles: got %0d want 256", n); end
        total++; if (ack !== 3'b100) begin bad++; $display("FAIL to_ack: got %b want 100", ack); end
        total++; if (err !== 3'b100) begin bad++; $display("FAIL to_err: got %b want 100", err); end
        total++; if ({bcd[2*BW +: BW], neg[2]} !== {12'h003, 1'b0}) begin bad++; $display("FAIL to_keep: got %h/%b want 003/0", bcd[2*BW +: BW], neg[2]); end
        req = '0;
        repeat (3) @(negedge clk);
        total++; if (err[2] !== 1'b1) begin bad++; $display("FAIL to_sticky: got %b want 1", err[2]); end
        req = 3'b100;
        wait_start(ok);
        repeat (9) @(negedge clk);
        pulse_dv(12'h003);
        total++; if ({ack, err[2]} !== 4'b1000) begin bad++; $display("FAIL to_clear: got %b want 1000", {ack, err[2]}); end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_dv_final();
        bit ok;
        value[0 +: W] = 10'd999; req = 3'b001;
        wait_start(ok);
        repeat (255) @(negedge clk);
        total++; if (ack !== '0) begin bad++; $display("FAIL fin_early: got %b want 000", ack); end
        pulse_dv(12'h999);
        total++; if ({ack, err[0]} !== 4'b0010) begin bad++; $display("FAIL fin_ack_err: got %b want 0010", {ack, err[0]}); end
        total++; if (bcd[0 +: BW] !== 12'h999) begin bad++; $display("FAIL fin_bcd: got %h want 999", bcd[0 +: BW]); end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit ok;
        int seen;
        value[W +: W] = 10'd7; req = 3'b010;
        wait_start(ok);
        repeat (10) @(negedge clk);
        rst = 1'b1; req = '0;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ack !== '0) seen++;
        end
        pulse_dv(12'h007);
        if (ack !== '0) seen++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (ack !== '0) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL rm_ack: got %0d acks want 0", seen); end
        total++; if ({bcd, neg, err} !== '0) begin bad++; $display("FAIL rm_results: got %h want 0", {bcd, neg, err}); end
        total++; if ({busy, conv_start, conv_bin} !== '0) begin bad++; $display("FAIL rm_idle: got %b want 0", {busy, conv_start, conv_bin}); end
    endtask

    initial begin
        rst = 1'b1; req = '0; value = '0; sgn = '0; conv_bcd = '0; conv_dv = 1'b0;
        test_reset();
        test_unsigned();
        test_signed();
        test_round_robin();
        test_timeout();
        test_dv_final();
        test_reset_mid();
        total++; if (multi_ack !== 0) begin bad++; $display("FAIL one_ack: got %0d multi-ack cycles want 0", multi_ack); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_bcd_convert_scheduler
`default_nettype wire
